tensor_core_controller: RTL
===========================

# tensor_core_controller

Sequencer that owns the tensor core register file on behalf of a byte-stream host. Accepts exactly NUMBER_OF_REGISTERS operand bytes over a valid/ready input stream and writes them through the register file's single-register write port. It then launches the tensor core, commits its result through the bulk write port, and streams all registers back out over a valid/ready output stream. It sits between the host interface and the register file/tensor core pair.

## Interface
- NUMBER_OF_REGISTERS, 32, register count; multiple of 16; M = (NUMBER_OF_REGISTERS-1)/16 + 1 matrices of 4x4 bytes
- clock_in  input  1  sole clock, rising edge
- reset_in  input  1  synchronous, active-high reset
- start_in  input  1  begin one load/compute/drain job; sampled only in IDLE
- load_valid_in  input  1  operand byte valid
- load_data_in  input  8  operand byte
- load_ready_out  output  1  controller accepts operand byte
- non_bulk_write_enable_out  output  1  to register file single write enable
- non_bulk_write_register_address_out  output  $clog2(NUMBER_OF_REGISTERS)  to register file single write address
- non_bulk_write_data_out  output  8  to register file single write data
- bulk_write_enable_out  output  1  to register file bulk write enable (bulk data routed tensor core -> register file directly)
- read_data_in  input  8 x [M][4][4]  register file read_data_out
- tensor_core_start_out  output  1  one-cycle compute launch pulse
- tensor_core_done_in  input  1  compute complete, level or pulse
- out_valid_out  output  1  result byte valid
- out_data_out  output  8  result byte
- out_ready_in  input  1  downstream accepts result byte
- busy_out  output  1  high in every state except IDLE
- done_out  output  1  one-cycle pulse on final drained byte

## Operation
- States: IDLE, LOAD, START, WAIT, WRITEBACK, DRAIN.
- IDLE: start_in=1 -> LOAD, address counter cleared to 0.
- LOAD: load_ready_out=1. A beat is load_valid_in && load_ready_out. Each beat drives non_bulk_write_enable_out=1, address=counter, data=load_data_in (combinational pass-through), then increments the counter. The beat at counter=NUMBER_OF_REGISTERS-1 -> START, counter cleared.
- START: tensor_core_start_out=1 for exactly this one cycle -> WAIT.
- WAIT: tensor_core_done_in=1 -> WRITEBACK. Done is ignored in START and in every other state.
- WRITEBACK: bulk_write_enable_out=1 for exactly one cycle -> DRAIN.
- DRAIN: out_valid_out=1. out_data_out = read_data_in[c/16][(c%16)/4][c%4] for counter c. Each out_valid_out && out_ready_in beat increments c. The beat at c=NUMBER_OF_REGISTERS-1 asserts done_out in the same cycle -> IDLE.
- The counter width is $clog2(NUMBER_OF_REGISTERS). The counter never wraps mid-phase; it is cleared explicitly at each phase change.
- Outside the stated states, every write enable, start, and valid output is 0.
- start_in outside IDLE is ignored, including in the done_out cycle.
- bulk and non-bulk enables are never asserted together.

## Timing
- Reset: state=IDLE, counter=0. All outputs 0, including load_ready_out, busy_out, done_out, and out_valid_out. Register file contents are not touched.
- Reset mid-job: the job is aborted at the next edge with no further writes. A partially loaded register file is left as is.
- State is registered. load_ready_out, out_valid_out, busy_out, tensor_core_start_out, and bulk_write_enable_out decode from state only. non_bulk_write_enable_out and done_out also depend combinationally on the handshake inputs.
- Load latency: byte visible in the register file the edge after its beat. Sustained rate 1 byte/cycle.
- Minimum job length: 1 (IDLE->LOAD) + N (load) + 1 (START) + >=1 (WAIT) + 1 (WRITEBACK) + N (drain) cycles.
- First out_valid_out cycle follows the WRITEBACK edge, so read_data_in already reflects the bulk result.
- Holding out_ready_in=0 stalls DRAIN indefinitely. out_data_out is stable while stalled.

## Structure
- Shared package tensor_core_pkg: state enum tensor_core_controller_state_t, and localparam for matrix count M = (NUMBER_OF_REGISTERS-1)/16+1 expressed as a function of the parameter.
- Single flat module. Counter, FSM, and output byte mux are inline. No sub-module.

## Test plan
- Reset then start_in=1, stream bytes 0x00..0x1F with load_valid_in held high -> 32 consecutive non-bulk writes at addresses 0..31 with data = address; one tensor_core_start_out pulse.
- Load with load_valid_in toggling 1,0,1,0 -> write enable only on valid cycles; address increments only on beats; exactly 32 writes.
- Model the tensor core to return done 5 cycles after start and supply bulk data 0xA0+i -> one bulk_write_enable_out pulse. Drain emits 0xA0..0xBF in address order; done_out on the 32nd beat; busy_out falls next cycle.
- Drain with out_ready_in low for 3 cycles at c=7 -> out_data_out held at byte 7; no skip or duplicate.
- reset_in asserted in WAIT, then done arrives -> no bulk write; IDLE; busy_out=0.
- start_in high during LOAD and on the done_out cycle -> ignored; a new job begins only on a later start_in in IDLE.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// Shared types for the tensor core controller: FSM state encoding and the
// matrix-count helper used to size the register file read bus.
package tensor_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_WRITEBACK,
    ST_DRAIN
  } tensor_core_controller_state_t;

  // Number of 4x4 byte matrices needed to hold n registers.
  function automatic int matrix_count(input int n);
    return (n - 1) / 16 + 1;
  endfunction

endpackage

// File: rtl/tensor_core_controller.sv
// Load / compute / drain sequencer between a byte-stream host and the tensor
// core register file.
module tensor_core_controller
  import tensor_core_pkg::*;
#(
  parameter int NUMBER_OF_REGISTERS = 32,
  localparam int M  = matrix_count(NUMBER_OF_REGISTERS),
  localparam int AW = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                            clock_in,
  input  logic                            reset_in,
  input  logic                            start_in,
  input  logic                            load_valid_in,
  input  logic [7:0]                      load_data_in,
  output logic                            load_ready_out,
  output logic                            non_bulk_write_enable_out,
  output logic [AW-1:0]                   non_bulk_write_register_address_out,
  output logic [7:0]                      non_bulk_write_data_out,
  output logic                            bulk_write_enable_out,
  input  logic [M-1:0][3:0][3:0][7:0]     read_data_in,
  output logic                            tensor_core_start_out,
  input  logic                            tensor_core_done_in,
  output logic                            out_valid_out,
  output logic [7:0]                      out_data_out,
  input  logic                            out_ready_in,
  output logic                            busy_out,
  output logic                            done_out
);

  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam logic [AW-1:0] LAST_INDEX = AW'(NUMBER_OF_REGISTERS - 1);

  tensor_core_controller_state_t state_reg, state_next;
  logic [AW-1:0] counter_reg, counter_next;
  logic [MW-1:0] matrix_sel;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_reg   <= ST_IDLE;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
    end
  end

  // Counter bits [3:2] pick the row, [1:0] the column, the rest the matrix.
  assign matrix_sel = MW'(counter_reg >> 4);

  always_comb begin
    state_next                          = state_reg;
    counter_next                        = counter_reg;
    load_ready_out                      = 1'b0;
    non_bulk_write_enable_out           = 1'b0;
    non_bulk_write_register_address_out = '0;
    non_bulk_write_data_out             = '0;
    bulk_write_enable_out               = 1'b0;
    tensor_core_start_out               = 1'b0;
    out_valid_out                       = 1'b0;
    out_data_out                        = '0;
    busy_out                            = (state_reg != ST_IDLE);
    done_out                            = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (start_in) begin
          state_next   = ST_LOAD;
          counter_next = '0;
        end
      end
      ST_LOAD: begin
        load_ready_out = 1'b1;
        if (load_valid_in) begin
          non_bulk_write_enable_out           = 1'b1;
          non_bulk_write_register_address_out = counter_reg;
          non_bulk_write_data_out             = load_data_in;
          if (counter_reg == LAST_INDEX) begin
            state_next   = ST_START;
            counter_next = '0;
          end else begin
            counter_next = counter_reg + AW'(1);
          end
        end
      end
      ST_START: begin
        tensor_core_start_out = 1'b1;
        state_next            = ST_WAIT;
      end
      ST_WAIT: begin
        if (tensor_core_done_in) state_next = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        bulk_write_enable_out = 1'b1;
        state_next            = ST_DRAIN;
        counter_next          = '0;
      end
      ST_DRAIN: begin
        out_valid_out = 1'b1;
        out_data_out  = read_data_in[matrix_sel][counter_reg[3:2]][counter_reg[1:0]];
        if (out_ready_in) begin
          if (counter_reg == LAST_INDEX) begin
            done_out     = 1'b1;
            state_next   = ST_IDLE;
            counter_next = '0;
          end else begin
            counter_next = counter_reg + AW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
